// File: rtl/bcd_updown_counter.sv
// Packed-BCD up/down counter with terminal wrap, parallel load and load
// validation. Count, wrap strobe and load-error strobe are all registered.
module bcd_updown_counter #(
  parameter int unsigned         DIGITS = 2,
  parameter logic [4*DIGITS-1:0] TOP    = 8'h59
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  input  logic                en,
  input  logic                up,
  output logic [4*DIGITS-1:0] count,
  output logic                wrap,
  output logic                load_err
);

  localparam int unsigned W = 4 * DIGITS;

  logic [W-1:0] r_count;
  logic         r_wrap;
  logic         r_load_err;

  logic [W-1:0] w_inc;
  logic [W-1:0] w_dec;
  logic [W-1:0] w_next_count;
  logic         w_next_wrap;
  logic         w_next_err;
  logic         w_count_ok;
  logic         w_load_ok;

  // True when every nibble of v is a decimal digit.
  function automatic logic digits_ok(input logic [W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  // Packed BCD compares correctly as binary once every nibble is a digit.
  assign w_count_ok = digits_ok(r_count) && (r_count <= TOP);
  assign w_load_ok  = digits_ok(load_val) && (load_val <= TOP);

  // Ripple BCD increment and decrement of the whole count in one cycle.
  always_comb begin
    logic       carry;
    logic       borrow;
    logic [3:0] d;
    w_inc  = '0;
    w_dec  = '0;
    carry  = 1'b1;
    borrow = 1'b1;
    d      = 4'd0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      d = r_count[4*i +: 4];
      if (carry) begin
        if (d == 4'd9) begin
          w_inc[4*i +: 4] = 4'd0;
        end else begin
          w_inc[4*i +: 4] = d + 4'd1;
          carry           = 1'b0;
        end
      end else begin
        w_inc[4*i +: 4] = d;
      end
      if (borrow) begin
        if (d == 4'd0) begin
          w_dec[4*i +: 4] = 4'd9;
        end else begin
          w_dec[4*i +: 4] = d - 4'd1;
          borrow          = 1'b0;
        end
      end else begin
        w_dec[4*i +: 4] = d;
      end
    end
  end

  // Next-state selection with priority clr > load > en.
  always_comb begin
    w_next_count = r_count;
    w_next_wrap  = 1'b0;
    w_next_err   = 1'b0;
    if (clr) begin
      w_next_count = '0;
    end else if (load) begin
      // A rejected load holds the count and also swallows this cycle's step.
      if (w_load_ok) begin
        w_next_count = load_val;
      end else begin
        w_next_err = 1'b1;
      end
    end else if (en) begin
      if (!w_count_ok) begin
        // Corrupted count recovers to zero and flags it like a wrap.
        w_next_count = '0;
        w_next_wrap  = 1'b1;
      end else if (up) begin
        if (r_count == TOP) begin
          w_next_count = '0;
          w_next_wrap  = 1'b1;
        end else begin
          w_next_count = w_inc;
        end
      end else begin
        if (r_count == '0) begin
          w_next_count = TOP;
          w_next_wrap  = 1'b1;
        end else begin
          w_next_count = w_dec;
        end
      end
    end
  end

  // State and strobe registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count    <= '0;
      r_wrap     <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_count    <= w_next_count;
      r_wrap     <= w_next_wrap;
      r_load_err <= w_next_err;
    end
  end

  assign count    = r_count;
  assign wrap     = r_wrap;
  assign load_err = r_load_err;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Scoreboard bench for bcd_updown_counter: a 2-digit instance (TOP=59) and a
// 3-digit instance (TOP=999). Stimulus pushes expectations; a negedge
// monitor pops and compares, and checks the BCD range invariant every cycle.
module tb_bcd_updown_counter;

  typedef struct packed {
    logic [11:0] cnt;
    logic        wrap;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  logic       a_clr, a_load, a_en, a_up;
  logic [7:0] a_lv;
  logic [7:0] a_count;
  logic       a_wrap, a_err;

  logic        b_clr, b_load, b_en, b_up;
  logic [11:0] b_lv;
  logic [11:0] b_count;
  logic        b_wrap, b_err;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bcd_updown_counter #(.DIGITS(2), .TOP(8'h59)) dut_a (
    .clk(clk), .rst(rst), .clr(a_clr), .load(a_load), .load_val(a_lv),
    .en(a_en), .up(a_up), .count(a_count), .wrap(a_wrap), .load_err(a_err)
  );

  bcd_updown_counter #(.DIGITS(3), .TOP(12'h999)) dut_b (
    .clk(clk), .rst(rst), .clr(b_clr), .load(b_load), .load_val(b_lv),
    .en(b_en), .up(b_up), .count(b_count), .wrap(b_wrap), .load_err(b_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] to_bcd2(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic ok2(input logic [7:0] v);
    return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (v <= 8'h59);
  endfunction

  function automatic logic ok3(input logic [11:0] v);
    return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (v[11:8] <= 4'd9);
  endfunction

  task automatic idle_a();
    a_clr = 1'b0; a_load = 1'b0; a_lv = 8'h00; a_en = 1'b0; a_up = 1'b0;
  endtask

  task automatic idle_b();
    b_clr = 1'b0; b_load = 1'b0; b_lv = 12'h000; b_en = 1'b0; b_up = 1'b0;
  endtask

  task automatic step_a(input logic c, input logic l, input logic [7:0] lv,
                        input logic e, input logic u,
                        input logic [7:0] ec, input logic ew, input logic ee);
    a_clr = c; a_load = l; a_lv = lv; a_en = e; a_up = u;
    @(posedge clk);
    qa.push_back('{cnt: 12'(ec), wrap: ew, err: ee});
    #1;
  endtask

  task automatic step_b(input logic c, input logic l, input logic [11:0] lv,
                        input logic e, input logic u,
                        input logic [11:0] ec, input logic ew, input logic ee);
    b_clr = c; b_load = l; b_lv = lv; b_en = e; b_up = u;
    @(posedge clk);
    qb.push_back('{cnt: ec, wrap: ew, err: ee});
    #1;
  endtask

  // Monitor: compare against the scoreboard and check range every cycle.
  always @(negedge clk) begin
    if (!rst) begin
      check("range_a", 32'(ok2(a_count)), 32'd1);
      check("range_b", 32'(ok3(b_count)), 32'd1);
      if (qa.size() > 0) begin
        ea = qa.pop_front();
        check("a_count", 32'(a_count), 32'(ea.cnt[7:0]));
        check("a_wrap", 32'(a_wrap), 32'(ea.wrap));
        check("a_load_err", 32'(a_err), 32'(ea.err));
      end
      if (qb.size() > 0) begin
        eb = qb.pop_front();
        check("b_count", 32'(b_count), 32'(eb.cnt));
        check("b_wrap", 32'(b_wrap), 32'(eb.wrap));
        check("b_load_err", 32'(b_err), 32'(eb.err));
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int v;
    // Reset held across edges: load/en must have no effect.
    rst = 1'b1;
    idle_b();
    a_clr = 1'b0; a_load = 1'b1; a_lv = 8'h42; a_en = 1'b1; a_up = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_count", 32'(a_count), 32'h00);
    check("rst_hold_wrap", 32'(a_wrap), 32'd0);
    check("rst_hold_err", 32'(a_err), 32'd0);
    idle_a();
    @(negedge clk);
    rst = 1'b0;

    // Up count 00..59,00 from reset; first edge after release gives 01.
    for (int i = 1; i <= 60; i++) begin
      step_a(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, to_bcd2(i % 60), 1'(i == 60), 1'b0);
    end
    idle_a();

    // Asynchronous reset pulse between edges.
    step_a(1'b0, 1'b1, 8'h37, 1'b0, 1'b0, 8'h37, 1'b0, 1'b0);
    idle_a();
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst_pulse_count", 32'(a_count), 32'h00);
    rst = 1'b0;

    // Reset during a load_err strobe clears it at once.
    a_load = 1'b1; a_lv = 8'h4A;
    @(posedge clk);
    #1;
    idle_a();
    check("strobe_err_pre", 32'(a_err), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("strobe_err_rst", 32'(a_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Reset during a wrap strobe (00 down -> 59) clears it at once.
    a_en = 1'b1; a_up = 1'b0;
    @(posedge clk);
    #1;
    idle_a();
    check("strobe_wrap_pre", 32'(a_wrap), 32'd1);
    check("strobe_wrap_cnt", 32'(a_count), 32'h59);
    #1 rst = 1'b1;
    #1;
    check("strobe_wrap_rst", 32'(a_wrap), 32'd0);
    check("strobe_cnt_rst", 32'(a_count), 32'h00);
    rst = 1'b0;
    @(negedge clk);
    step_a(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0);

    // Down count from 10 through 00 to 59, 58.
    step_a(1'b0, 1'b1, 8'h10, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);
    for (int i = 1; i <= 12; i++) begin
      v = (10 - i + 60) % 60;
      step_a(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, to_bcd2(v), 1'(v == 59), 1'b0);
    end

    // Load validation and priority.
    step_a(1'b0, 1'b1, 8'h42, 1'b0, 1'b0, 8'h42, 1'b0, 1'b0);
    step_a(1'b0, 1'b1, 8'h4A, 1'b0, 1'b0, 8'h42, 1'b0, 1'b1);
    step_a(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h42, 1'b0, 1'b0);
    step_a(1'b0, 1'b1, 8'h60, 1'b0, 1'b0, 8'h42, 1'b0, 1'b1);
    step_a(1'b1, 1'b1, 8'h15, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
    step_a(1'b0, 1'b1, 8'h33, 1'b1, 1'b1, 8'h33, 1'b0, 1'b0);
    step_a(1'b0, 1'b1, 8'h5F, 1'b1, 1'b1, 8'h33, 1'b0, 1'b1);
    step_a(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h34, 1'b0, 1'b0);
    step_a(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h34, 1'b0, 1'b0);
    step_a(1'b0, 1'b1, 8'h59, 1'b0, 1'b0, 8'h59, 1'b0, 1'b0);

    // Direction reversal at the terminal value: wrap on every edge.
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) step_a(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0);
      else            step_a(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h59, 1'b1, 1'b0);
    end
    idle_a();

    // Three-digit instance: full ripple and terminal wrap.
    step_b(1'b0, 1'b1, 12'h998, 1'b0, 1'b0, 12'h998, 1'b0, 1'b0);
    step_b(1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 12'h999, 1'b0, 1'b0);
    step_b(1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 12'h000, 1'b1, 1'b0);
    step_b(1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 12'h001, 1'b0, 1'b0);
    step_b(1'b0, 1'b1, 12'h099, 1'b0, 1'b0, 12'h099, 1'b0, 1'b0);
    step_b(1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 12'h100, 1'b0, 1'b0);
    step_b(1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 12'h099, 1'b0, 1'b0);
    step_b(1'b0, 1'b1, 12'h9A0, 1'b0, 1'b0, 12'h099, 1'b0, 1'b1);
    step_b(1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0);
    step_b(1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 12'h999, 1'b1, 1'b0);
    idle_b();

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 32'(qa.size() + qb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_updown_counter.md
BCD_UPDOWN_COUNTER -- requirements
Module: bcd_updown_counter

Interface
REQ-001 Parameter DIGITS, default 2: number of BCD digits; legal range 1..8.
REQ-002 Parameter TOP, default 8'h59 (width 4*DIGITS): packed-BCD terminal value; every nibble SHALL be 0..9.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 clr  input  1  synchronous clear to zero.
REQ-006 load  input  1  synchronous parallel load request.
REQ-007 load_val  input  4*DIGITS  packed-BCD load value; digit 0 in bits [3:0].
REQ-008 en  input  1  count enable.
REQ-009 up  input  1  direction: 1 = increment, 0 = decrement.
REQ-010 count  output  4*DIGITS  registered packed-BCD count; digit 0 in bits [3:0].
REQ-011 wrap  output  1  registered one-cycle strobe, high in the cycle after a terminal wrap.
REQ-012 load_err  output  1  registered one-cycle strobe, high in the cycle after a rejected load.

Function
REQ-013 All outputs SHALL be registered; a qualifying input sampled at edge N SHALL be visible on count, wrap and load_err after edge N.
REQ-014 Per-edge priority SHALL be: clr > load > en. Lower-priority requests in the same cycle are ignored.
REQ-015 clr=1: count SHALL become 0; wrap=0; load_err=0.
REQ-016 load=1 with a valid load_val SHALL copy load_val into count; wrap=0; load_err=0.
REQ-017 load_val is valid when every nibble is 0..9 and its value is <= TOP.
REQ-018 load=1 with an invalid load_val SHALL leave count unchanged, set load_err=1 for one cycle, and suppress counting that cycle.
REQ-019 en=0 with no clr or load SHALL hold count; wrap=0; load_err=0.
REQ-020 en=1, up=1, count != TOP: count SHALL increment by 1 in BCD. Digit 0 increments. A digit at 9 becomes 0 and carries into the next digit, rippling through all digits in the same cycle.
REQ-021 en=1, up=1, count == TOP: count SHALL become 0 and wrap SHALL be 1 for one cycle.
REQ-022 en=1, up=0, count != 0: count SHALL decrement by 1 in BCD. A digit at 0 becomes 9 and borrows from the next digit.
REQ-023 en=1, up=0, count == 0: count SHALL become TOP and wrap SHALL be 1 for one cycle.
REQ-024 Every nibble of count SHALL always hold 0..9, and count SHALL always be <= TOP.
REQ-025 If count is out of range (only possible via X or SEU), the next enabled step SHALL force count to 0 with wrap=1.
REQ-026 up may change on any cycle. The direction sampled at the edge applies; no extra latency and no lost step on reversal.
REQ-027 wrap and load_err SHALL be 0 in every cycle not explicitly specified above, and SHALL never stay high for two consecutive cycles unless the triggering condition recurs.
REQ-028 With TOP=0, an enabled step in either direction SHALL keep count at 0 and assert wrap every enabled cycle.

Reset
REQ-029 rst=1 SHALL immediately, without waiting for clk, force count=0, wrap=0 and load_err=0.
REQ-030 While rst=1, clr, load and en SHALL have no effect.
REQ-031 Reset asserted mid-operation (including during a wrap or load_err strobe) SHALL clear that strobe at once.
REQ-032 The first edge after rst deasserts SHALL be a normal functional edge.

Verification (DIGITS=2, TOP=8'h59 unless stated)
REQ-033 Reset: rst pulse between edges -> count=8'h00, wrap=0 and load_err=0 before the next rising edge. Counting resumes 8'h01 on the first enabled up edge after release.
REQ-034 Up count and wrap: en=1, up=1 from 8'h00 for 60 edges. Sequence 00,01..09,10..59,00. wrap=1 only in the cycle count returns to 00. Also check 8'h09->8'h10 and 8'h19->8'h20 carries.
REQ-035 Down count and wrap: load 8'h10, then en=1, up=0. Sequence 10,09,08..00,59,58. wrap=1 only in the cycle showing 59.
REQ-036 Load checks and priority:
  - load 8'h42 -> count=42.
  - load 8'h4A -> count holds, load_err=1 for one cycle.
  - load 8'h60 -> rejected, load_err=1.
  - clr=1 with load=1 and en=1 -> count=00, load_err=0.
  - load=1 with en=1 -> loaded value appears, no increment.
REQ-037 Direction reversal: at count=8'h59, assert up=1 for one edge (-> 00, wrap=1), then up=0 for one edge (-> 59, wrap=1). Repeat alternately for 10 edges; wrap=1 on every edge.
REQ-038 Parameter sweep: DIGITS=3, TOP=12'h999, up count from 12'h998. Sequence 999 then 000 with wrap=1; 12'h099->12'h100 ripple in one edge. Invariant REQ-024 checked every cycle of every test.
